// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and MEM->WB bundle layout for pipeline stages
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // MEM->WB bundle field widths, packed MSB-first as RW,M2R,MDATA,ALU,RD,LS
    localparam int RW_W     = 1;
    localparam int M2R_W    = 1;
    localparam int MDATA_W  = 32;
    localparam int ALU_W    = 32;
    localparam int RD_W     = 5;
    localparam int LS_W     = 3;

    localparam int LS_LSB    = 0;
    localparam int RD_LSB    = LS_LSB + LS_W;
    localparam int ALU_LSB   = RD_LSB + RD_W;
    localparam int MDATA_LSB = ALU_LSB + ALU_W;
    localparam int M2R_LSB   = MDATA_LSB + MDATA_W;
    localparam int RW_LSB    = M2R_LSB + M2R_W;

    localparam int MEM_WB_W = RW_W + M2R_W + MDATA_W + ALU_W + RD_W + LS_W;

    typedef struct packed {
        logic               rw;
        logic               m2r;
        logic [MDATA_W-1:0] mdata;
        logic [ALU_W-1:0]   alu;
        logic [RD_W-1:0]    rd;
        logic [LS_W-1:0]    ls;
    } mem_wb_t;

    function automatic logic [1:0] occupancy_of(input pipe_state_t st);
        case (st)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - data register with load enable, synchronous clear and async reset
module pipe_slot #(
    parameter int               WIDTH      = 74,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // clear wins over load so a squash never lets a new bundle slip in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_DATA;
        end else if (clear) begin
            q <= RESET_DATA;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with flush and 2-entry skid buffer
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH             = MEM_WB_W,
    parameter logic [WIDTH-1:0] RESET_DATA        = '0,
    parameter bit               FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [1:0]       Occupancy
);

    pipe_state_t      state;
    pipe_state_t      state_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic             clear_slots;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Handshake outputs depend only on state (and Reset), never on OutReady.
    assign InReady   = !Reset && (state != FULL);
    assign OutValid  = (state != EMPTY);
    assign OutData   = main_q;
    assign Occupancy = occupancy_of(state);

    assign in_fire  = InValid && InReady;
    assign out_fire = OutValid && OutReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        clear_slots    = 1'b0;
        if (Flush) begin
            state_next  = EMPTY;
            clear_slots = FLUSH_CLEARS_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_next = FULL;
                        skid_load  = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // the skid entry moves up; InReady is low so InData is ignored
                    if (out_fire) begin
                        state_next     = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : InData;

    pipe_slot #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .clk   (Clk),
        .rst   (Reset),
        .load  (main_load),
        .clear (clear_slots),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clk   (Clk),
        .rst   (Reset),
        .load  (skid_load),
        .clear (clear_slots),
        .d     (InData),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int W = 74;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Flush;
    logic         InValid;
    logic         OutReady;
    logic [W-1:0] InData;

    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    logic         nc_in_ready, nc_out_valid;
    logic [W-1:0] nc_out_data;
    logic [1:0]   nc_occ;

    logic         w1_in_ready, w1_out_valid;
    logic [0:0]   w1_out_data;
    logic [1:0]   w1_occ;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    pipe_stage_skid dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InReady(in_ready), .InData(InData),
        .OutValid(out_valid), .OutReady(OutReady), .OutData(out_data),
        .Occupancy(occ)
    );

    pipe_stage_skid #(.WIDTH(74), .FLUSH_CLEARS_DATA(1'b0)) dut_nc (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InReady(nc_in_ready), .InData(InData),
        .OutValid(nc_out_valid), .OutReady(OutReady), .OutData(nc_out_data),
        .Occupancy(nc_occ)
    );

    pipe_stage_skid #(.WIDTH(1), .FLUSH_CLEARS_DATA(1'b0)) dut_w1 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InReady(w1_in_ready), .InData(InData[0:0]),
        .OutValid(w1_out_valid), .OutReady(OutReady), .OutData(w1_out_data),
        .Occupancy(w1_occ)
    );

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ov;
        logic [W-1:0] od;
        logic         chk_od;
        logic [1:0]   occ;
        logic         ird;
    } vec_t;

    vec_t tbl[$];
    logic [W-1:0] mq[$];

    function automatic vec_t mk(logic fl, logic iv, logic [W-1:0] id, logic ordy,
                                logic ov, logic [W-1:0] od, logic chk_od,
                                logic [1:0] o, logic ird);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.chk_od = chk_od; v.occ = o; v.ird = ird;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic fl, input logic iv, input logic [W-1:0] id, input logic ordy);
        Flush = fl; InValid = iv; InData = id; OutReady = ordy;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic         fl, iv, ordy, pre_ready, pre_valid;
        logic [95:0]  rnd;

        // reset state
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;
        @(posedge Clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_occ", W'(occ), W'(0));
        chk("rst_out_data", out_data, W'(0));
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_release_in_ready", W'(in_ready), W'(1));
        @(posedge Clk);
        #1;

        // streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, W'(i), 1'b1);
            chk($sformatf("stream_data_%0d", i), out_data, W'(i));
            chk($sformatf("stream_valid_%0d", i), W'(out_valid), W'(1));
            chk($sformatf("stream_occ_%0d", i), W'(occ), W'(1));
        end
        step(1'b0, 1'b0, '0, 1'b1);
        chk("stream_drain_valid", W'(out_valid), W'(0));

        // table: back-pressure, simultaneous fire, flush
        tbl.push_back(mk(0, 1, 'h11, 0, 1, 'h11, 1, 1, 1));
        tbl.push_back(mk(0, 1, 'h22, 0, 1, 'h11, 1, 2, 0));
        tbl.push_back(mk(0, 1, 'h33, 0, 1, 'h11, 1, 2, 0));
        tbl.push_back(mk(0, 1, 'h33, 0, 1, 'h11, 1, 2, 0));
        tbl.push_back(mk(0, 1, 'h33, 1, 1, 'h22, 1, 1, 1));
        tbl.push_back(mk(0, 1, 'h33, 1, 1, 'h33, 1, 1, 1));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h00, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h05, 0, 1, 'h05, 1, 1, 1));
        tbl.push_back(mk(0, 1, 'h06, 1, 1, 'h06, 1, 1, 1));
        tbl.push_back(mk(0, 0, 'h00, 0, 1, 'h06, 1, 1, 1));
        tbl.push_back(mk(0, 1, 'h07, 1, 1, 'h07, 1, 1, 1));
        tbl.push_back(mk(0, 1, 'h77, 0, 1, 'h07, 1, 2, 0));
        tbl.push_back(mk(1, 1, 'h88, 1, 0, 'h00, 1, 0, 1));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h00, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'h99, 1, 1, 'h99, 1, 1, 1));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h00, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h44, 0, 1, 'h44, 1, 1, 1));
        tbl.push_back(mk(1, 1, 'h55, 1, 0, 'h00, 1, 0, 1));
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(tbl[i].ov));
            chk($sformatf("vec%0d_occ", i), W'(occ), W'(tbl[i].occ));
            chk($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(tbl[i].ird));
            if (tbl[i].chk_od) chk($sformatf("vec%0d_data", i), out_data, tbl[i].od);
        end

        // flush without clearing data, WIDTH=74 and WIDTH=1
        do_reset();
        step(1'b0, 1'b1, 'h35, 1'b0);
        step(1'b0, 1'b1, 'h4A, 1'b0);
        chk("sweep_full_occ", W'(nc_occ), W'(2));
        step(1'b1, 1'b1, 'h66, 1'b1);
        chk("sweep_clr_valid", W'(out_valid), W'(0));
        chk("sweep_clr_data", out_data, W'(0));
        chk("sweep_nc_valid", W'(nc_out_valid), W'(0));
        chk("sweep_nc_data", nc_out_data, W'('h35));
        chk("sweep_w1_valid", W'(w1_out_valid), W'(0));
        chk("sweep_w1_data", W'(w1_out_data), W'(1));
        chk("sweep_w1_occ", W'(w1_occ), W'(0));
        step(1'b0, 1'b0, '0, 1'b1);
        chk("sweep_nc_hold", nc_out_data, W'('h35));
        chk("sweep_nc_ready", W'(nc_in_ready), W'(1));

        // async reset while FULL
        step(1'b0, 1'b1, 'h12, 1'b0);
        step(1'b0, 1'b1, 'h34, 1'b0);
        chk("prerst_occ", W'(occ), W'(2));
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("midrst_valid", W'(out_valid), W'(0));
        chk("midrst_occ", W'(occ), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(0));
        chk("midrst_data", out_data, W'(0));
        @(negedge Clk);
        Reset = 1'b0;
        InValid = 1'b0;
        #1;
        chk("postrst_in_ready", W'(in_ready), W'(1));
        chk("postrst_valid", W'(out_valid), W'(0));
        @(posedge Clk);
        #1;

        // randomized traffic against a queue model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            fl   = ($urandom % 25) == 0;
            iv   = ($urandom % 4) != 0;
            ordy = ($urandom % 3) != 0;
            rnd  = {$urandom, $urandom, $urandom};
            Flush = fl; InValid = iv; OutReady = ordy; InData = rnd[W-1:0];
            @(posedge Clk);
            pre_ready = mq.size() < 2;
            pre_valid = mq.size() > 0;
            if (fl) begin
                mq.delete();
            end else begin
                if (pre_valid && ordy) void'(mq.pop_front());
                if (iv && pre_ready) mq.push_back(rnd[W-1:0]);
            end
            #1;
            chk("rnd_valid", W'(out_valid), W'(mq.size() > 0));
            chk("rnd_occ", W'(occ), W'(mq.size()));
            chk("rnd_in_ready", W'(in_ready), W'(mq.size() < 2));
            if (mq.size() > 0) begin
                chk("rnd_data", out_data, mq[0]);
                chk("rnd_w1_data", W'(w1_out_data), W'(mq[0][0]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
